iter_divider: RTL and testbench

//   Multi-cycle radix-2 restoring divider that answers the ALU's div/complete request.

---
 rtl/iter_divider.sv | 136 +++++++++++++
 tb/tb_iter_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for DIV.W/DIVU.W/MOD.W/MOD.WU.
// Handshake: the requester raises div and holds it high until complete.
// complete pulses for one cycle, and s/r are valid in that cycle.
// Dropping div while the divider is busy aborts the operation; no complete follows.
// s/r then keep their previous values.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             complete,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] ay_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic            sx_q;
  logic            sy_q;
  logic            sgn_q;
  logic [CW-1:0]   count_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;
  logic            complete_q;
  logic            busy_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic             fits_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] ax_d;
  logic [WIDTH-1:0] ay_d;
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] r_d;

  // One restoring step, operand magnitudes and final sign correction.
  // quo_q starts out holding |x|; its MSBs shift into rem as quotient bits shift in.
  always_comb begin
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, ay_q};
    fits_d    = (shifted_d >= {1'b0, ay_q});
    rem_d     = fits_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], fits_d};
    ax_d      = (div_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    ay_d      = (div_signed && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
    s_d       = (sgn_q && (sx_q ^ sy_q)) ? (~quo_d + WIDTH'(1)) : quo_d;
    r_d       = (sgn_q && sx_q) ? (~rem_d + WIDTH'(1)) : rem_d;
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ay_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      sgn_q      <= 1'b0;
      count_q    <= '0;
      s_q        <= '0;
      r_q        <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          complete_q <= 1'b0;
          if (div) begin
            quo_q   <= ax_d;
            ay_q    <= ay_d;
            sx_q    <= div_signed & x[WIDTH-1];
            sy_q    <= div_signed & y[WIDTH-1];
            sgn_q   <= div_signed;
            rem_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!div) begin
            // Flush: discard the partial result and leave s/r untouched.
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + CW'(1);
            if (count_q == LAST) begin
              s_q        <= s_d;
              r_q        <= r_d;
              complete_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          complete_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          complete_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign complete  = complete_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed scenarios, then randomized operations checked against an arithmetic reference model.
module tb_iter_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         div;
  logic         div_signed;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic         complete;
  logic         busy;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_s;
  logic [W-1:0]   last_r;

  iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .div(div), .div_signed(div_signed),
    .x(x), .y(y), .s(s), .r(r), .complete(complete), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: plain integer division, plus the defined divide-by-zero and overflow results.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         output logic [W-1:0] qs, output logic [W-1:0] rs);
    logic signed [W-1:0] as_;
    logic signed [W-1:0] bs_;
    as_ = a;
    bs_ = b;
    if (b == '0) begin
      qs = (sg && a[W-1]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      rs = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      qs = 32'h8000_0000;
      rs = '0;
    end else if (sg) begin
      qs = as_ / bs_;
      rs = as_ % bs_;
    end else begin
      qs = a / b;
      rs = a % b;
    end
  endtask

  // Driver: request one division and return at the negedge where complete is seen.
  // lat counts the negedges after the accepting edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input bit scramble, input bit keep, output int lat);
    @(negedge clk);
    div = 1'b1; x = a; y = b; div_signed = sg;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (complete) break;
      if (scramble) begin
        x = $urandom; y = $urandom; div_signed = 1'($urandom_range(0, 1));
      end
    end
    if (!keep) div = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; div = 1'b0; div_signed = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    checks++; if (s !== '0) begin errors++; $display("FAIL reset_s: got %h expected 0", s); end
    checks++; if (r !== '0) begin errors++; $display("FAIL reset_r: got %h expected 0", r); end
    checks++; if (complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b expected 0", complete); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL unsigned_latency: got %0d expected 33", lat); end
    checks++; if (s !== 32'h0000_000E) begin errors++; $display("FAIL unsigned_s: got %h expected 0000000e", s); end
    checks++; if (r !== 32'h0000_0002) begin errors++; $display("FAIL unsigned_r: got %h expected 00000002", r); end
    @(negedge clk);
    checks++; if (complete !== 1'b0) begin errors++; $display("FAIL complete_one_cycle: got %b expected 0", complete); end
    repeat (3) @(negedge clk);
    checks++; if (s !== 32'h0000_000E || r !== 32'h0000_0002) begin
      errors++; $display("FAIL result_hold: got %h/%h expected 0000000e/00000002", s, r);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_signed_and_corners();
    logic [W-1:0] tx[5] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000, 32'h0000_0005, 32'hFFFF_FFFB};
    logic [W-1:0] ty[5] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    logic         tg[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ts[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [W-1:0] tr[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFB};
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(tx[i], ty[i], tg[i], 1'b0, 1'b0, lat);
      checks++; if (lat != 33) begin errors++; $display("FAIL case%0d_latency: got %0d expected 33", i, lat); end
      checks++; if (s !== ts[i]) begin errors++; $display("FAIL case%0d_s: got %h expected %h", i, s, ts[i]); end
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL case%0d_r: got %h expected %h", i, r, tr[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, lat);
    x = 32'd50; y = 32'd5; div_signed = 1'b0;
    gap = 0;
    while (gap < 100) begin
      @(negedge clk);
      gap++;
      if (complete) break;
    end
    div = 1'b0;
    checks++; if (gap != 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", gap); end
    checks++; if (s !== 32'd10) begin errors++; $display("FAIL b2b_s: got %h expected 0000000a", s); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL b2b_r: got %h expected 00000000", r); end
  endtask

  task automatic test_stability();
    int lat;
    do_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 1'b0, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL stable_latency: got %0d expected 33", lat); end
    checks++; if (s !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL stable_result: got %h/%h expected fffffffd/ffffffff", s, r);
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    do_op(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, lat);
    @(negedge clk);
    div = 1'b1; x = 32'd77; y = 32'd2; div_signed = 1'b0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (complete) seen++; end
    div = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    repeat (40) begin @(negedge clk); if (complete) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_complete: got %0d pulses expected 0", seen); end
    checks++; if (s !== 32'd333 || r !== 32'd1) begin
      errors++; $display("FAIL abort_hold: got %h/%h expected 0000014d/00000001", s, r);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 1'b0, lat);
    @(negedge clk);
    div = 1'b1; x = 32'd999; y = 32'd4; div_signed = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (s !== '0 || r !== '0) begin errors++; $display("FAIL midreset_sr: got %h/%h expected 0/0", s, r); end
    checks++; if (complete !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_ctl: got complete=%b busy=%b expected 0/0", complete, busy);
    end
    @(negedge clk);
    reset = 1'b0; div = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (complete) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_nocomplete: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_random();
    int lat;
    int k;
    int seen;
    int mode;
    logic [W-1:0] a, b, qs, rs;
    logic [2*W-1:0] e;
    logic sg;
    // Establish a known result so the first abort has something to hold.
    ref_div(32'd12345, 32'd67, 1'b0, last_s, last_r);
    do_op(32'd12345, 32'd67, 1'b0, 1'b0, 1'b0, lat);
    checks++; if (s !== last_s || r !== last_r) begin
      errors++; $display("FAIL rand_seed: got %h/%h expected %h/%h", s, r, last_s, last_r);
    end
    for (int n = 0; n < 500; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      mode = $urandom_range(0, 9);
      a = $urandom; b = $urandom; sg = 1'($urandom_range(0, 1));
      if (mode == 0) b = '0;
      else if (mode == 1) b = W'($urandom_range(1, 15));
      else if (mode == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 3) a = W'($urandom_range(0, 1000));
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 32);
        @(negedge clk);
        div = 1'b1; x = a; y = b; div_signed = sg;
        seen = 0;
        repeat (k) begin @(negedge clk); if (complete) seen++; end
        div = 1'b0;
        @(negedge clk);
        if (complete) seen++;
        checks++; if (seen != 0 || busy !== 1'b0) begin
          errors++; $display("FAIL rand_abort%0d: got pulses=%0d busy=%b expected 0/0", n, seen, busy);
        end
        checks++; if (s !== last_s || r !== last_r) begin
          errors++; $display("FAIL rand_abort_hold%0d: got %h/%h expected %h/%h", n, s, r, last_s, last_r);
        end
      end else begin
        ref_div(a, b, sg, qs, rs);
        exp_q.push_back({qs, rs});
        do_op(a, b, sg, 1'($urandom_range(0, 1)), 1'b0, lat);
        e = exp_q.pop_front();
        last_s = e[2*W-1:W];
        last_r = e[W-1:0];
        checks++; if (lat != 33) begin errors++; $display("FAIL rand_latency%0d: got %0d expected 33", n, lat); end
        checks++; if (s !== last_s || r !== last_r) begin
          errors++;
          $display("FAIL rand_result%0d: x=%h y=%h sg=%b got %h/%h expected %h/%h", n, a, b, sg, s, r, last_s, last_r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_and_corners();
    test_back_to_back();
    test_stability();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
